multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle successor to the single-cycle decode/control unit.
- Sequences each MIPS instruction through fetch/decode/execute/memory/writeback states and drives the shared-datapath control strobes.
- Handshakes with a variable-latency unified memory and traps on illegal encodings or memory timeouts.
- Sits between the instruction register/ALU/register file and the memory port.

Parameters:
- ALUCTL_W, 4: ALU control width; 4-bit codes zero-extended, must be >=4.
- ENABLE_MULT, 1: 1 = funct 0x18 is legal (mult); 0 = funct 0x18 traps.
- MEM_TIMEOUT, 0: maximum wait cycles per memory access; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- instr  in  32  current instruction register contents (opcode [31:26], funct [5:0])
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (branch)
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_ctl  out  ALUCTL_W  ALU operation
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data, 0 = ALUOut
- illegal  out  1  sticky illegal-instruction flag
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- State register is 4 bits; outputs decode from state (Moore), except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- Reset: while rst=1, all outputs are 0. State goes to FETCH, the wait counter goes to 0, and illegal and mem_err clear on the edge.
- Any output not listed for a state is 0. alu_ctl is ADD (0010) in every state except RTEX and BRANCH.
- ALU codes:
  - add 0x20 -> 0010
  - sub 0x22 -> 0110
  - and 0x24 -> 0000
  - or 0x25 -> 0001
  - slt 0x2A -> 0111
  - mult 0x18 -> 1111
- States and transitions:
  - FETCH: mem_req=1, iord=0, a=0, b=01. On mem_ready: ir_write=1, pc_write=1, pc_src=00, next DECODE. Otherwise hold.
  - DECODE: a=0, b=11 (branch target precomputed into ALUOut). Next state by opcode:
    - 0x00 -> RTEX, if funct is legal
    - 0x23 or 0x2B -> MEMADR
    - 0x08 -> ADDIEX
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - any other opcode or illegal funct -> TRAP
  - MEMADR: a=1, b=10. Next MEMRD if opcode is 0x23, else MEMWR.
  - MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready -> FETCH.
  - RTEX: a=1, b=00, alu_ctl from funct -> RTWB.
  - RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - ADDIEX: a=1, b=10 -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0 -> FETCH.
  - BRANCH: a=1, b=00, alu_ctl=0110, pc_write_cond=1, pc_src=01 -> FETCH.
  - JUMP: pc_write=1, pc_src=10 -> FETCH.
  - TRAP: all strobes 0. Holds until rst.
- Latency with zero-wait memory (cycles per instruction):
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
  - With MEM_TIMEOUT>0, when the counter equals MEM_TIMEOUT and mem_ready is still 0, the next state is TRAP and mem_err is set.
  - If mem_ready=1 on that same cycle, the access completes normally; mem_ready wins.
- illegal is set on the DECODE->TRAP edge. illegal and mem_err are sticky until rst.
- instr must be stable from DECODE until the instruction returns to FETCH; the block samples it only in DECODE, MEMADR and RTEX.
- rst asserted mid-instruction, including mid-wait: the instruction is aborted, and there is no write strobe in the reset cycle.

Test Plan:
- lw (0x8C..., opcode 0x23) with mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles; reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type add (funct 0x20) then sub (0x22) -> alu_ctl=0010 then 0110 in RTEX; reg_dst=1 and reg_write=1 in RTWB; 4 cycles each.
- sw with mem_ready held low 3 cycles in MEMWR, MEM_TIMEOUT=0 -> mem_req=1 and mem_we=1 held for 4 cycles; no trap; back to FETCH.
- MEM_TIMEOUT=2, mem_ready low in FETCH -> TRAP after 3 cycles, mem_err=1, all strobes 0 until rst. Repeat with mem_ready rising on the timeout cycle -> normal DECODE.
- opcode 0x3F, or funct 0x18 with ENABLE_MULT=0 -> DECODE->TRAP, illegal=1 and sticky; rst then clears it and state returns to FETCH.
- beq (0x04) -> 3 cycles, pc_write_cond=1 and pc_src=01 in cycle 3. j (0x02) -> pc_write=1 and pc_src=10 in cycle 3. rst asserted in MEMRD -> next state FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS control sequencer with memory handshake, timeout and illegal-op traps
module multicycle_control_fsm #(
  parameter int ALUCTL_W    = 4,
  parameter int ENABLE_MULT = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                mem_err
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB,
    ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } state_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  state_t        r_state, w_next;
  logic [CW-1:0] r_wait;
  logic          r_illegal, r_mem_err;
  logic [5:0]    w_op, w_fn;
  logic [3:0]    w_alu_code;
  logic          w_fn_ok, w_waiting, w_timeout, w_unused;
  assign w_op     = instr[31:26];
  assign w_fn     = instr[5:0];
  assign w_unused = ^instr[25:6];
  always_comb begin
    w_alu_code = w_fn == 6'h20 ? 4'b0010 :
                 w_fn == 6'h22 ? 4'b0110 :
                 w_fn == 6'h24 ? 4'b0000 :
                 w_fn == 6'h25 ? 4'b0001 :
                 w_fn == 6'h2A ? 4'b0111 : 4'b1111;
    w_fn_ok    = w_fn == 6'h20 || w_fn == 6'h22 || w_fn == 6'h24 || w_fn == 6'h25 ||
                 w_fn == 6'h2A || (ENABLE_MULT != 0 && w_fn == 6'h18);
    w_waiting  = (r_state == FETCH || r_state == MEMRD || r_state == MEMWR) && !mem_ready;
    w_timeout  = MEM_TIMEOUT != 0 && w_waiting && r_wait == CW'(MEM_TIMEOUT);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: w_next = (w_op == 6'h00 && w_fn_ok)    ? RTEX   :
                       (w_op == 6'h23 || w_op == 6'h2B) ? MEMADR :
                       w_op == 6'h08 ? ADDIEX :
                       w_op == 6'h04 ? BRANCH :
                       w_op == 6'h02 ? JUMP   : TRAP;
      MEMADR: w_next = w_op == 6'h23 ? MEMRD : MEMWR;
      MEMRD:  w_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next = mem_ready ? FETCH : MEMWR;
      RTEX:   w_next = RTWB;
      ADDIEX: w_next = ADDIWB;
      TRAP:   w_next = TRAP;
      default: w_next = FETCH;
    endcase
    if (w_timeout) w_next = TRAP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next != r_state) ? '0 : w_waiting ? r_wait + CW'(1) : r_wait;
      if (r_state == DECODE && w_next == TRAP) r_illegal <= 1'b1;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end
  // Moore decode; only the FETCH load strobes look at mem_ready, and reset forces everything low
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctl       = '0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    if (!rst) begin
      alu_ctl = ALUCTL_W'(4'b0010);
      case (r_state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        RTEX: begin
          alu_src_a = 1'b1;
          alu_ctl   = ALUCTL_W'(w_alu_code);
        end
        RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDIWB: reg_write = 1'b1;
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctl       = ALUCTL_W'(4'b0110);
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
    illegal = r_illegal & ~rst;
    mem_err = r_mem_err & ~rst;
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: vector table plus scoreboard for two parameterisations of the control FSM
module tb_multicycle_control_fsm;
  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic [31:0] instr0 = '0, instr1 = '0;
  logic        rdy0 = 1'b0, rdy1 = 1'b0;
  wire  [19:0] v0, v1;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm u0 (
    .clk(clk), .rst(rst0), .instr(instr0), .mem_ready(rdy0),
    .mem_req(v0[19]), .mem_we(v0[18]), .iord(v0[17]), .ir_write(v0[16]),
    .pc_write(v0[15]), .pc_write_cond(v0[14]), .pc_src(v0[13:12]),
    .alu_src_a(v0[11]), .alu_src_b(v0[10:9]), .alu_ctl(v0[8:5]),
    .reg_write(v0[4]), .reg_dst(v0[3]), .mem_to_reg(v0[2]),
    .illegal(v0[1]), .mem_err(v0[0])
  );
  multicycle_control_fsm #(.ENABLE_MULT(0), .MEM_TIMEOUT(2)) u1 (
    .clk(clk), .rst(rst1), .instr(instr1), .mem_ready(rdy1),
    .mem_req(v1[19]), .mem_we(v1[18]), .iord(v1[17]), .ir_write(v1[16]),
    .pc_write(v1[15]), .pc_write_cond(v1[14]), .pc_src(v1[13:12]),
    .alu_src_a(v1[11]), .alu_src_b(v1[10:9]), .alu_ctl(v1[8:5]),
    .reg_write(v1[4]), .reg_dst(v1[3]), .mem_to_reg(v1[2]),
    .illegal(v1[1]), .mem_err(v1[0])
  );
  localparam logic [19:0] REQ = 20'h80000, WE = 20'h40000, IORD = 20'h20000, IRW = 20'h10000;
  localparam logic [19:0] PCW = 20'h08000, PCWC = 20'h04000, SRC1 = 20'h01000, SRC2 = 20'h02000;
  localparam logic [19:0] A = 20'h00800, B1 = 20'h00200, B2 = 20'h00400, B3 = 20'h00600;
  localparam logic [19:0] ADD = 20'h00040, SUB = 20'h000C0, AND = 20'h00000, OR = 20'h00020;
  localparam logic [19:0] SLT = 20'h000E0, MUL = 20'h001E0;
  localparam logic [19:0] RW = 20'h00010, RD = 20'h00008, M2R = 20'h00004, ILL = 20'h00002, MERR = 20'h00001;
  localparam logic [19:0] E_F = REQ | IRW | PCW | B1 | ADD, E_FW = REQ | B1 | ADD, E_D = B3 | ADD;
  localparam logic [19:0] E_MA = A | B2 | ADD, E_MR = REQ | IORD | ADD, E_WB = RW | M2R | ADD;
  localparam logic [19:0] E_MW = REQ | WE | IORD | ADD, E_RW = RW | RD | ADD, E_AX = A | B2 | ADD;
  localparam logic [19:0] E_AW = RW | ADD, E_BR = A | SUB | PCWC | SRC1, E_J = PCW | SRC2 | ADD, E_TR = ADD;
  localparam logic [31:0] LW = 32'h8C01_0004, SW = 32'hAC01_0004, ADDI = 32'h2001_0005;
  localparam logic [31:0] BEQ = 32'h1022_0003, JMP = 32'h0800_0010, BAD = 32'hFC00_0000;
  localparam logic [31:0] RT = 32'h0022_1800;
  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;
  typedef struct {
    logic [19:0] exp;
    string       nm;
  } sb_t;
  vec_t tv[$];
  sb_t  sbq[$];
  task automatic add(input logic r, input logic [31:0] ins, input logic m, input logic [19:0] e);
    tv.push_back('{r, ins, m, e});
  endtask
  task automatic step(input int d, input logic r, input logic [31:0] ins, input logic m,
                      input logic [19:0] e, input string nm);
    sb_t        s;
    logic [19:0] act;
    @(posedge clk);
    #1;
    if (d == 0) begin rst0 = r; instr0 = ins; rdy0 = m; end
    else begin rst1 = r; instr1 = ins; rdy1 = m; end
    sbq.push_back('{e, nm});
    @(negedge clk);
    s   = sbq.pop_front();
    act = (d == 0) ? v0 : v1;
    n_chk++;
    if (act !== s.exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", s.nm, act, s.exp);
    end
  endtask
  initial begin
    logic [5:0]  fn[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18};
    logic [19:0] alu[6] = '{ADD, SUB, AND, OR, SLT, MUL};
    add(1, LW, 1, '0);
    add(0, LW, 1, E_F); add(0, LW, 1, E_D); add(0, LW, 1, E_MA); add(0, LW, 1, E_MR); add(0, LW, 1, E_WB);
    add(0, SW, 1, E_F); add(0, SW, 1, E_D); add(0, SW, 1, E_MA);
    add(0, SW, 0, E_MW); add(0, SW, 0, E_MW); add(0, SW, 0, E_MW); add(0, SW, 1, E_MW);
    add(0, ADDI, 0, E_FW); add(0, ADDI, 1, E_F); add(0, ADDI, 1, E_D); add(0, ADDI, 1, E_AX); add(0, ADDI, 1, E_AW);
    add(0, BEQ, 1, E_F); add(0, BEQ, 1, E_D); add(0, BEQ, 1, E_BR);
    add(0, JMP, 1, E_F); add(0, JMP, 1, E_D); add(0, JMP, 1, E_J);
    add(0, LW, 1, E_F); add(0, LW, 1, E_D); add(0, LW, 1, E_MA); add(0, LW, 0, E_MR); add(1, LW, 0, '0);
    add(0, BAD, 1, E_F); add(0, BAD, 1, E_D); add(0, BAD, 1, E_TR | ILL); add(0, BAD, 0, E_TR | ILL);
    add(1, BAD, 1, '0);
    for (int i = 0; i < tv.size(); i++)
      step(0, tv[i].rst, tv[i].ins, tv[i].rdy, tv[i].exp, $sformatf("row%0d", i));
    for (int i = 0; i < 6; i++) begin
      step(0, 0, RT | 32'(fn[i]), 1, E_F, $sformatf("rt%0d_fetch", i));
      step(0, 0, RT | 32'(fn[i]), 1, E_D, $sformatf("rt%0d_decode", i));
      step(0, 0, RT | 32'(fn[i]), 1, A | alu[i], $sformatf("rt%0d_ex", i));
      step(0, 0, RT | 32'(fn[i]), 1, E_RW, $sformatf("rt%0d_wb", i));
    end
    step(1, 1, RT, 0, '0, "to_rst");
    step(1, 0, RT, 0, E_FW, "to_w0");
    step(1, 0, RT, 0, E_FW, "to_w1");
    step(1, 0, RT, 0, E_FW, "to_w2");
    step(1, 0, RT, 1, E_TR | MERR, "to_trap");
    step(1, 0, RT, 1, E_TR | MERR, "to_hold");
    step(1, 1, SW, 0, '0, "to_clr");
    step(1, 0, SW, 0, E_FW, "win_w0");
    step(1, 0, SW, 0, E_FW, "win_w1");
    step(1, 0, SW, 1, E_F, "win_fetch");
    step(1, 0, SW, 1, E_D, "win_decode");
    step(1, 0, SW, 1, E_MA, "win_memadr");
    step(1, 0, SW, 0, E_MW, "win_mw0");
    step(1, 0, SW, 0, E_MW, "win_mw1");
    step(1, 0, SW, 1, E_MW, "win_mw2");
    step(1, 0, RT | 32'h18, 1, E_F, "nomul_fetch");
    step(1, 0, RT | 32'h18, 1, E_D, "nomul_decode");
    step(1, 0, RT | 32'h18, 1, E_TR | ILL, "nomul_trap");
    step(1, 1, RT | 32'h18, 1, '0, "nomul_rst");
    step(1, 0, RT | 32'h18, 0, E_FW, "nomul_clean");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
